// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event FIFO: bus offsets, CTRL bits, debounce states.
package keypad_pkg;

    localparam int unsigned KEY_W  = 4;
    localparam int unsigned DATA_W = 16;

    localparam logic [3:0] KP_DATA   = 4'h0;
    localparam logic [3:0] KP_STATUS = 4'h2;
    localparam logic [3:0] KP_CTRL   = 4'h4;

    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_CLR_OVF = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } kp_state_t;

endpackage

// File: rtl/key_fifo.sv
// Synchronous circular FIFO with flush; count/full/empty are registered alongside the pointers.
module key_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout_c,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot, so a push into a full FIFO is accepted when a pop accompanies it.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout_c  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == CW'(0));
        end
    end

endmodule

// File: rtl/keypad_event_fifo.sv
// Debounces scanner key presses into single events, queues them, and exposes them on the CPU bus.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] DB_CYCLES = 16'd20000
) (
    input  logic              clk,
    input  logic              isReset_n,
    input  logic [KEY_W-1:0]  key_value,
    input  logic              is_pressed,
    input  logic              isCS,
    input  logic              isW,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] dR,
    output logic [DATA_W-1:0] dW,
    output logic              irq
);
    localparam int unsigned CW = $clog2(DEPTH+1);

    kp_state_t         state;
    logic [15:0]       cnt;
    logic [KEY_W-1:0]  cand;
    logic              push_c;
    logic              pop_c;
    logic              flush_c;
    logic              rd_sel;
    logic              st_sel;
    logic              wr_ctrl;
    logic              rd_q;
    logic              overflow;
    logic              irq_en;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [KEY_W-1:0]  head_c;
    logic [DATA_W-1:0] rdata_c;
    logic              unused_dr;

    assign unused_dr = ^dR[DATA_W-1:3];

    assign rd_sel  = isCS & ~isW & (addr == KP_DATA);
    assign st_sel  = isCS & ~isW & (addr == KP_STATUS);
    assign wr_ctrl = isCS &  isW & (addr == KP_CTRL);
    assign flush_c = wr_ctrl & dR[CTRL_FLUSH];
    assign pop_c   = rd_sel & ~rd_q & ~empty;

    // Push fires on the edge where the stable-press count reaches DB_CYCLES.
    always_comb begin
        push_c = 1'b0;
        if (state == IDLE) begin
            push_c = is_pressed && (DB_CYCLES == 16'd1);
        end else if (state == PRESS_WAIT) begin
            push_c = is_pressed && (key_value == cand) && (cnt + 16'd1 >= DB_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (!isReset_n) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_pressed) begin
                        cand  <= key_value;
                        cnt   <= 16'd1;
                        state <= (DB_CYCLES == 16'd1) ? HELD : PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!is_pressed) begin
                        state <= IDLE;
                    end else if (key_value != cand) begin
                        cand <= key_value;
                        cnt  <= 16'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (cnt + 16'd1 >= DB_CYCLES) begin
                            state <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (!is_pressed) begin
                        cnt   <= 16'd1;
                        state <= (DB_CYCLES == 16'd1) ? IDLE : RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (is_pressed) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (cnt + 16'd1 >= DB_CYCLES) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Overflow clear requests take priority over a same-cycle dropped push.
    always_ff @(posedge clk) begin
        if (!isReset_n) begin
            rd_q     <= 1'b0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rd_q <= rd_sel;
            irq  <= irq_en & ~empty;
            if (wr_ctrl) begin
                irq_en <= dR[CTRL_IRQ_EN];
            end
            if (wr_ctrl && (dR[CTRL_FLUSH] || dR[CTRL_CLR_OVF])) begin
                overflow <= 1'b0;
            end else if (push_c && full && !pop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (isReset_n),
        .push   (push_c),
        .pop    (pop_c),
        .flush  (flush_c),
        .din    (cand),
        .dout_c (head_c),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_comb begin
        rdata_c = {overflow, irq_en, full, empty, 7'b0, 5'(count)};
        if (rd_sel) begin
            rdata_c = empty ? 16'h0000 : {1'b1, 11'b0, head_c};
        end
    end

    assign dW = (rd_sel || st_sel) ? rdata_c : 16'hzzzz;

endmodule
